// File: rtl/odometer_pkg.sv
// Shared constants and state type for the RVT odometer measurement block.
// Also used by the register-interface block to size its result fields.
package odometer_pkg;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_SETTLE = 3'd1,
      ST_COUNT  = 3'd2,
      ST_DRAIN  = 3'd3,
      ST_DONE   = 3'd4
   } state_e;

   localparam int CW_DEF          = 16;
   localparam int WW_DEF          = 16;
   localparam int SETTLE_CYC_DEF  = 8;
   localparam int SYNC_STAGES_DEF = 2;

   function automatic logic is_busy(input state_e s);
      return (s == ST_SETTLE) || (s == ST_COUNT) || (s == ST_DRAIN);
   endfunction

   function automatic logic is_osc_on(input state_e s);
      return (s == ST_SETTLE) || (s == ST_COUNT);
   endfunction

endpackage

// File: rtl/odometer_edge_counter.sv
// Synchronizer, rising-edge detector and saturating counter for one
// asynchronous ring-oscillator input.
module odometer_edge_counter
   import odometer_pkg::*;
#(
   parameter int CW          = CW_DEF,
   parameter int SYNC_STAGES = SYNC_STAGES_DEF
) (
   input  logic          CLK,
   input  logic          RST,
   input  logic          CLR,
   input  logic          GATE,
   input  logic          ASYNC_IN,
   output logic [CW-1:0] CNT,
   output logic          SAT
);

   localparam logic [CW-1:0] MAX_CNT = '1;

   logic [SYNC_STAGES-1:0] r_sync;
   logic                   r_hist;
   logic [CW-1:0]          r_cnt;
   logic                   r_sat;
   logic                   w_rise;
   logic                   w_inc;

   always_ff @(posedge CLK) begin
      if (RST) begin
         r_sync <= '0;
         r_hist <= 1'b0;
      end else begin
         r_sync <= {r_sync[SYNC_STAGES-2:0], ASYNC_IN};
         r_hist <= r_sync[SYNC_STAGES-1];
      end
   end

   assign w_rise = r_sync[SYNC_STAGES-1] & ~r_hist;
   assign w_inc  = GATE & w_rise & (r_cnt != MAX_CNT);

   // SAT marks that the counter reached full scale during this measurement
   always_ff @(posedge CLK) begin
      if (RST || CLR) begin
         r_cnt <= '0;
         r_sat <= 1'b0;
      end else if (w_inc) begin
         r_cnt <= r_cnt + 1'b1;
         if (r_cnt == MAX_CNT - 1'b1) begin
            r_sat <= 1'b1;
         end
      end
   end

   assign CNT = r_cnt;
   assign SAT = r_sat;

endmodule

// File: rtl/odometer_rosc_counter.sv
// Odometer measurement top: runs both ROSCs, counts their edges over a
// CLK-timed window and reports both counts and their signed difference.
module odometer_rosc_counter
   import odometer_pkg::*;
#(
   parameter int CW          = CW_DEF,
   parameter int WW          = WW_DEF,
   parameter int SETTLE_CYC  = SETTLE_CYC_DEF,
   parameter int SYNC_STAGES = SYNC_STAGES_DEF
) (
   input  logic          CLK,
   input  logic          RST,
   input  logic          START,
   input  logic [WW-1:0] WIN_CYC,
   input  logic          ACK,
   input  logic          ROSC_STR,
   input  logic          ROSC_REF,
   output logic          EN_STR,
   output logic          EN_REF,
   output logic          BUSY,
   output logic          VALID,
   output logic [CW-1:0] CNT_STR,
   output logic [CW-1:0] CNT_REF,
   output logic [CW:0]   DIFF,
   output logic [1:0]    SAT
);

   localparam logic [WW-1:0] SETTLE_LD = WW'(SETTLE_CYC - 1);
   localparam logic [WW-1:0] DRAIN_LD  = WW'(SYNC_STAGES);

   state_e                 r_state;
   logic [WW-1:0]          r_tmr;
   logic [WW-1:0]          r_win;
   logic [SYNC_STAGES-1:0] r_gate;
   logic [CW:0]            r_diff;
   logic                   w_accept;
   logic                   w_gate;
   logic [CW-1:0]          w_cnt_str;
   logic [CW-1:0]          w_cnt_ref;
   logic                   w_sat_str;
   logic                   w_sat_ref;

   assign w_accept = START &&
                     ((r_state == ST_IDLE) || ((r_state == ST_DONE) && ACK));

   always_ff @(posedge CLK) begin
      if (RST) begin
         r_state <= ST_IDLE;
         r_tmr   <= '0;
         r_win   <= '0;
         r_diff  <= '0;
      end else if (w_accept) begin
         r_state <= ST_SETTLE;
         r_tmr   <= SETTLE_LD;
         r_win   <= WIN_CYC;
         r_diff  <= '0;
      end else begin
         unique case (r_state)
            ST_IDLE: begin
               r_state <= ST_IDLE;
            end
            ST_SETTLE: begin
               if (r_tmr != '0) begin
                  r_tmr <= r_tmr - 1'b1;
               end else if (r_win == '0) begin
                  r_state <= ST_DRAIN;
                  r_tmr   <= DRAIN_LD;
               end else begin
                  r_state <= ST_COUNT;
                  r_tmr   <= r_win - 1'b1;
               end
            end
            ST_COUNT: begin
               if (r_tmr != '0) begin
                  r_tmr <= r_tmr - 1'b1;
               end else begin
                  r_state <= ST_DRAIN;
                  r_tmr   <= DRAIN_LD;
               end
            end
            // counters are final in the last drain cycle
            ST_DRAIN: begin
               if (r_tmr != '0) begin
                  r_tmr <= r_tmr - 1'b1;
               end else begin
                  r_state <= ST_DONE;
                  r_diff  <= {1'b0, w_cnt_ref} - {1'b0, w_cnt_str};
               end
            end
            ST_DONE: begin
               if (ACK) begin
                  r_state <= ST_IDLE;
               end
            end
            default: begin
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

   // gate delayed to line the window up with the synchronizer input
   always_ff @(posedge CLK) begin
      if (RST) begin
         r_gate <= '0;
      end else begin
         r_gate <= {r_gate[SYNC_STAGES-2:0], (r_state == ST_COUNT)};
      end
   end

   assign w_gate = r_gate[SYNC_STAGES-1];

   odometer_edge_counter #(
      .CW          (CW),
      .SYNC_STAGES (SYNC_STAGES)
   ) u_cnt_str (
      .CLK      (CLK),
      .RST      (RST),
      .CLR      (w_accept),
      .GATE     (w_gate),
      .ASYNC_IN (ROSC_STR),
      .CNT      (w_cnt_str),
      .SAT      (w_sat_str)
   );

   odometer_edge_counter #(
      .CW          (CW),
      .SYNC_STAGES (SYNC_STAGES)
   ) u_cnt_ref (
      .CLK      (CLK),
      .RST      (RST),
      .CLR      (w_accept),
      .GATE     (w_gate),
      .ASYNC_IN (ROSC_REF),
      .CNT      (w_cnt_ref),
      .SAT      (w_sat_ref)
   );

   assign EN_STR  = is_osc_on(r_state);
   assign EN_REF  = is_osc_on(r_state);
   assign BUSY    = is_busy(r_state);
   assign VALID   = (r_state == ST_DONE);
   assign CNT_STR = w_cnt_str;
   assign CNT_REF = w_cnt_ref;
   assign DIFF    = r_diff;
   assign SAT     = {w_sat_ref, w_sat_str};

endmodule

// File: tb/tb_odometer_rosc_counter.sv
// Directed bench for odometer_rosc_counter: a 16-bit and an 8-bit instance
// share stimulus and are compared every cycle against an edge-count model.
`timescale 1ns/1ps
module tb_odometer_rosc_counter;

   localparam int SET = 8;
   localparam int SYN = 2;

   logic        CLK = 1'b0;
   logic        RST = 1'b1;
   logic        START = 1'b0;
   logic        ACK = 1'b0;
   logic        ROSC_STR = 1'b0;
   logic        ROSC_REF = 1'b0;
   logic [15:0] WIN_CYC = '0;

   logic        en_s, en_r, busy, valid;
   logic [15:0] cs, cr;
   logic [16:0] diff;
   logic [1:0]  sat;

   logic        en_s8, en_r8, busy8, valid8;
   logic [7:0]  cs8, cr8;
   logic [8:0]  diff8;
   logic [1:0]  sat8;

   int n_run = 0;
   int n_fail = 0;

   int f_str = 0, f_ref = 0, ph_s = 0, ph_r = 0;

   int m_mode = 0, m_rel = 0, m_win = 0, n_s = 0, n_r = 0;
   bit m_init = 0, m_clean = 0, p_s = 0, p_r = 0, m_acc = 0;

   odometer_rosc_counter dut (
      .CLK(CLK), .RST(RST), .START(START), .WIN_CYC(WIN_CYC), .ACK(ACK),
      .ROSC_STR(ROSC_STR), .ROSC_REF(ROSC_REF),
      .EN_STR(en_s), .EN_REF(en_r), .BUSY(busy), .VALID(valid),
      .CNT_STR(cs), .CNT_REF(cr), .DIFF(diff), .SAT(sat)
   );

   odometer_rosc_counter #(.CW(8)) dut8 (
      .CLK(CLK), .RST(RST), .START(START), .WIN_CYC(WIN_CYC), .ACK(ACK),
      .ROSC_STR(ROSC_STR), .ROSC_REF(ROSC_REF),
      .EN_STR(en_s8), .EN_REF(en_r8), .BUSY(busy8), .VALID(valid8),
      .CNT_STR(cs8), .CNT_REF(cr8), .DIFF(diff8), .SAT(sat8)
   );

   always #5 CLK = ~CLK;

   // oscillators: phase in percent of a CLK-relative period, f in MHz at 100 MHz CLK
   always @(negedge CLK) begin
      ph_s = (ph_s + f_str) % 100;
      ph_r = (ph_r + f_ref) % 100;
      ROSC_STR = (f_str != 0) && (ph_s >= 50);
      ROSC_REF = (f_ref != 0) && (ph_r >= 50);
   end

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      n_run++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
      end
   endtask

   function automatic int clip(input int n, input int mx);
      return (n > mx) ? mx : n;
   endfunction

   task automatic check_all();
      bit run_e, en_e;
      int es, er, es8, er8;
      run_e = (m_mode == 1);
      en_e  = run_e && (m_rel + 1 <= SET + m_win);
      chk("valid", valid, m_mode == 2);
      chk("busy", busy, run_e);
      chk("en_str", en_s, en_e);
      chk("en_ref", en_r, en_e);
      chk("valid8", valid8, m_mode == 2);
      chk("en_ref8", en_r8, en_e);
      if (m_mode == 2 || (m_mode == 0 && m_clean)) begin
         es  = m_clean ? 0 : clip(n_s, 65535);
         er  = m_clean ? 0 : clip(n_r, 65535);
         es8 = m_clean ? 0 : clip(n_s, 255);
         er8 = m_clean ? 0 : clip(n_r, 255);
         chk("cnt_str", cs, es);
         chk("cnt_ref", cr, er);
         chk("diff", 32'($signed(diff)), 32'(er - es));
         chk("sat", sat, {er >= 65535, es >= 65535});
         chk("cnt_str8", cs8, es8);
         chk("cnt_ref8", cr8, er8);
         chk("diff8", 32'($signed(diff8)), 32'(er8 - es8));
         chk("sat8", sat8, {er8 >= 255, es8 >= 255});
      end
   endtask

   // model: count input rising edges sampled during the window cycles
   always @(posedge CLK) begin
      if (RST) begin
         m_mode  = 0;
         m_init  = 1;
         m_clean = 1;
      end else if (m_init) begin
         m_acc = START && (m_mode == 0 || (m_mode == 2 && ACK));
         if (m_mode == 1) begin
            m_rel++;
            if (m_rel > SET && m_rel <= SET + m_win) begin
               if (ROSC_STR && !p_s) n_s++;
               if (ROSC_REF && !p_r) n_r++;
            end
            if (m_rel + 1 >= SET + m_win + SYN + 2) m_mode = 2;
         end else if (m_mode == 2 && ACK) begin
            m_mode = 0;
         end
         if (m_acc) begin
            m_mode  = 1;
            m_rel   = 0;
            m_win   = int'(WIN_CYC);
            n_s     = 0;
            n_r     = 0;
            m_clean = 0;
         end
      end
      p_s = ROSC_STR;
      p_r = ROSC_REF;
      #1;
      if (m_init) check_all();
   end

   task automatic run(input int win, input bit with_ack,
                      input int pulse_at, output int lat);
      @(negedge CLK);
      START = 1'b1;
      ACK = with_ack;
      WIN_CYC = 16'(win);
      @(negedge CLK);
      START = 1'b0;
      ACK = 1'b0;
      if (with_ack) begin
         chk("sa_valid_low", valid, 1'b0);
         chk("sa_en_high", en_s, 1'b1);
      end
      lat = 1;
      while (valid !== 1'b1 && lat < 5000) begin
         START = (lat == pulse_at);
         ACK = (lat == pulse_at);
         @(negedge CLK);
         lat++;
      end
      START = 1'b0;
      ACK = 1'b0;
   endtask

   task automatic ack_only();
      @(negedge CLK);
      ACK = 1'b1;
      @(negedge CLK);
      ACK = 1'b0;
      chk("ack_valid", valid, 1'b0);
      chk("ack_en", en_s, 1'b0);
      chk("ack_busy", busy, 1'b0);
   endtask

   initial begin
      int lat;
      repeat (3) @(negedge CLK);
      RST = 1'b0;
      chk("rst_cnt_ref", cr, 0);

      f_ref = 10;
      f_str = 8;
      run(1000, 1'b0, 50, lat);
      chk("nom_latency", lat, 1012);
      chk("nom_cnt_ref", cr, 100);
      chk("nom_cnt_str", cs, 80);
      chk("nom_diff", 32'($signed(diff)), 20);
      chk("model_nom_ref", n_r, 100);
      repeat (3) @(negedge CLK);
      chk("done_frozen_ref", cr, 100);
      ack_only();

      run(0, 1'b0, 0, lat);
      chk("win0_latency", lat, 12);
      chk("win0_cnt_ref", cr, 0);
      chk("win0_diff", 32'($signed(diff)), 0);

      f_str = 0;
      f_ref = 5;
      run(200, 1'b1, 0, lat);
      chk("stop_latency", lat, 212);
      chk("stop_cnt_str", cs, 0);
      chk("stop_cnt_ref", cr, 10);
      chk("stop_diff", 32'($signed(diff)), 10);
      ack_only();

      f_ref = 20;
      f_str = 8;
      run(2000, 1'b0, 0, lat);
      chk("sat_latency", lat, 2012);
      chk("sat8_cnt_ref", cr8, 255);
      chk("sat8_cnt_str", cs8, 160);
      chk("sat8_flags", sat8, 2'b10);
      chk("sat8_diff", 32'($signed(diff8)), 95);
      chk("sat16_cnt_ref", cr, 400);
      chk("sat16_flags", sat, 2'b00);
      chk("sat16_diff", 32'($signed(diff)), 240);
      ack_only();

      f_ref = 10;
      @(negedge CLK);
      START = 1'b1;
      WIN_CYC = 16'd1000;
      @(negedge CLK);
      START = 1'b0;
      repeat (100) @(negedge CLK);
      RST = 1'b1;
      @(negedge CLK);
      chk("abort_en", en_s, 1'b0);
      chk("abort_busy", busy, 1'b0);
      chk("abort_valid", valid, 1'b0);
      chk("abort_cnt_ref", cr, 0);
      chk("abort_cnt_str", cs, 0);
      repeat (2) @(negedge CLK);
      RST = 1'b0;
      repeat (1100) @(negedge CLK);
      chk("abort_no_valid", valid, 1'b0);

      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end

endmodule
